// File: rtl/wb128_mem_responder.sv
// ---------------------------------------------------------------------------
// wb128_mem_responder
//   Wishbone B3 classic responder for a 128-bit data bus. It holds MEM_WORDS
//   128-bit words. Each cyc/stb request is answered with a single-cycle ack
//   (or err) after WAIT_STATES wait cycles. A backdoor load port lets the
//   bench preload memory contents.
//
//   Optional feature: define WB_RESP_ADDR_CHECK_EN to answer requests outside
//   [BASE_ADDR, BASE_ADDR + 16*MEM_WORDS) with o_wb_err. Such requests perform
//   no write and return zero data. When the macro is undefined, o_wb_err stays
//   0 and out-of-range addresses wrap modulo MEM_WORDS.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge) and asynchronous active-low reset
//   i_wb_adr         byte address; bits [3:0] are ignored
//   i_wb_sel         byte enables; bit n selects data[8n+7:8n]
//   i_wb_we          1 = write, 0 = read
//   i_wb_dat         write data
//   i_wb_cyc/i_wb_stb  bus cycle / request strobe
//   o_wb_dat         read data; held until the next response
//   o_wb_ack/o_wb_err  single-cycle completion / error pulse
//   i_ld_we/i_ld_idx/i_ld_dat  backdoor full-word preload
//   o_busy           high while the FSM is not idle
// ---------------------------------------------------------------------------
module wb128_mem_responder #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [31:0]                  i_wb_adr,
  input  logic [15:0]                  i_wb_sel,
  input  logic                         i_wb_we,
  input  logic [127:0]                 i_wb_dat,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  output logic [127:0]                 o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  input  logic                         i_ld_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_ld_idx,
  input  logic [127:0]                 i_ld_dat,
  output logic                         o_busy
);

  localparam int         AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [AW-1:0]  r_idx;
  logic [15:0]    r_sel;
  logic           r_we;
  logic [127:0]   r_dat;
  logic           r_oor;
  logic [127:0]   r_rdat;
  logic           r_ack;
  logic           r_err;
  logic [127:0]   r_mem [MEM_WORDS];

  logic [31:0]    w_off;
  logic [AW-1:0]  w_idx;
  logic           w_oor;
  logic           w_req;
  logic           w_bus_wr;
  logic           w_unused_off;

  // Keep bytes of old_w whose enable is clear; take the others from new_w.
  function automatic logic [127:0] merge_bytes(input logic [127:0] old_w,
                                               input logic [127:0] new_w,
                                               input logic [15:0]  sel);
    logic [127:0] res;
    res = old_w;
    for (int n = 0; n < 16; n++) begin
      if (sel[n]) res[8*n +: 8] = new_w[8*n +: 8];
    end
    return res;
  endfunction

  assign w_off        = i_wb_adr - BASE_ADDR;
  assign w_idx        = w_off[AW+3:4];
  assign w_unused_off = ^w_off;
  assign w_req        = i_wb_cyc && i_wb_stb;

`ifdef WB_RESP_ADDR_CHECK_EN
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 4;
  // If the address is below the base, w_off wraps. Reject that case separately.
  assign w_oor = (i_wb_adr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
`else
  assign w_oor = 1'b0;
`endif

  // Request / response FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_oor   <= 1'b0;
      r_rdat  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_idx <= w_idx;
            r_sel <= i_wb_sel;
            r_we  <= i_wb_we;
            r_dat <= i_wb_dat;
            r_oor <= w_oor;
            r_cnt <= WS;
            if (WS == 4'd0) begin
              // No wait cycles: respond directly from the live address.
              r_state <= ST_RESP;
              r_ack   <= !w_oor;
              r_err   <= w_oor;
              r_rdat  <= w_oor ? '0 : r_mem[w_idx];
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A dropped cyc abandons the transfer. Abort wins over the count.
          if (!i_wb_cyc) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
            r_ack   <= !r_oor;
            r_err   <= r_oor;
            r_rdat  <= r_oor ? '0 : r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory: the bus write commits on the edge leaving RESP.
  assign w_bus_wr = (r_state == ST_RESP) && r_we && !r_oor;

  always_ff @(posedge i_clk) begin
    if (w_bus_wr) r_mem[r_idx] <= merge_bytes(r_mem[r_idx], r_dat, r_sel);
    // If the bus write and the preload hit the same word, the bus write takes precedence.
    if (i_ld_we && !(w_bus_wr && (i_ld_idx == r_idx))) r_mem[i_ld_idx] <= i_ld_dat;
  end

  assign o_wb_dat = r_rdat;
  assign o_wb_ack = r_ack;
  assign o_wb_err = r_err;
  assign o_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb128_mem_responder.sv
module tb_wb128_mem_responder;

  localparam int MW = 256;

  localparam logic [127:0] W0   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W2   = 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE;
  localparam logic [127:0] Q2   = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;
  localparam logic [127:0] W3   = 128'hF0081003_E59F0010_E3A01000_E3A00001;
  localparam logic [127:0] W7   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W9   = 128'h99999999_0000FFFF_12345678_9ABCDEF0;
  localparam logic [127:0] W255 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] W3B  = 128'h11081003_E59F0010_E3A01000_E3A00022;
  localparam logic [127:0] ALLA = {16{8'hAA}};
  localparam logic [127:0] ALLF = {16{8'hFF}};
  localparam logic [127:0] ALL5 = {16{8'h55}};

  typedef struct {
    logic [127:0] dat;
    logic         err;
  } exp_t;

  typedef struct {
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic         we;
    logic [127:0] wdat;
    logic [127:0] edat;
    logic         eerr;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  adr = '0;
  logic [15:0]  sel = '0;
  logic         we = 1'b0;
  logic [127:0] wdat = '0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  int           cur = 0;
  logic         ld_we = 1'b0;
  logic [7:0]   ld_idx = '0;
  logic [127:0] ld_dat = '0;

  logic [127:0] dat_o [3];
  logic [2:0]   ack_o;
  logic [2:0]   err_o;
  logic [2:0]   busy_o;
  logic [2:0]   cyc_g;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=0, instance 1: WAIT_STATES=1, instance 2: WAIT_STATES=3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    assign cyc_g[g] = cyc && (cur == g);
    wb128_mem_responder #(
      .MEM_WORDS  (MW),
      .WAIT_STATES(WSG),
      .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_wb_adr(adr),
      .i_wb_sel(sel),
      .i_wb_we (we),
      .i_wb_dat(wdat),
      .i_wb_cyc(cyc_g[g]),
      .i_wb_stb(stb),
      .o_wb_dat(dat_o[g]),
      .o_wb_ack(ack_o[g]),
      .o_wb_err(err_o[g]),
      .i_ld_we (ld_we),
      .i_ld_idx(ld_idx),
      .i_ld_dat(ld_dat),
      .o_busy  (busy_o[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic ld(input int idx, input logic [127:0] d);
    ld_we = 1'b1; ld_idx = 8'(idx); ld_dat = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Called at a negedge with the target idle. Returns one idle cycle after the response.
  task automatic xfer(input int d, input logic [31:0] a, input logic [15:0] s, input logic w,
                      input logic [127:0] wd, input logic [127:0] ed, input logic ee,
                      input int elat);
    exp_t e;
    int   lat;
    logic got;
    sb.push_back('{ed, ee});
    cur = d; adr = a; sel = s; we = w; wdat = wd; cyc = 1'b1; stb = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack_o[d] || err_o[d]) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      n_chk++;
      $display("FAIL xfer_timeout adr=%h: no ack/err after %0d cycles, required one", a, lat);
    end else begin
      chk($sformatf("ack_err adr=%h", a), 128'({ack_o[d], err_o[d]}), 128'({!e.err, e.err}));
      chk($sformatf("latency adr=%h", a), 128'(lat), 128'(elat));
      if (!w || e.err) chk($sformatf("rdata adr=%h", a), dat_o[d], e.dat);
    end
    @(negedge clk);
  endtask

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int   seen;
    int   nack;
    int   last;
    exp_t e;
    logic [31:0] badr[4];

    vt[0]  = '{32'h0000_0030, 16'hFFFF, 1'b0, '0, W3, 1'b0};
    vt[1]  = '{32'h0000_0050, 16'h000F, 1'b1, ALLA, '0, 1'b0};
    vt[2]  = '{32'h0000_0050, 16'hFFFF, 1'b0, '0, 128'h0000_0000_0000_0000_0000_0000_AAAA_AAAA, 1'b0};
    vt[3]  = '{32'h0000_0070, 16'hF000, 1'b1, 128'hDEADBEEF_00000000_00000000_00000000, '0, 1'b0};
    vt[4]  = '{32'h0000_007C, 16'hFFFF, 1'b0, '0, 128'hDEADBEEF_89ABCDEF_FEDCBA98_76543210, 1'b0};
    vt[5]  = '{32'h0000_0000, 16'h0000, 1'b1, ALLF, '0, 1'b0};
    vt[6]  = '{32'h0000_0008, 16'hFFFF, 1'b0, '0, W0, 1'b0};
    vt[7]  = '{32'h0000_0030, 16'h8001, 1'b1, 128'h11000000_00000000_00000000_00000022, '0, 1'b0};
    vt[8]  = '{32'h0000_0030, 16'hFFFF, 1'b0, '0, W3B, 1'b0};
    vt[9]  = '{32'h0000_0FF0, 16'hFFFF, 1'b0, '0, W255, 1'b0};
`ifdef WB_RESP_ADDR_CHECK_EN
    vt[10] = '{32'h0000_1000, 16'hFFFF, 1'b0, '0, '0, 1'b1};
    vt[11] = '{32'h0000_1030, 16'hFFFF, 1'b1, ALL5, '0, 1'b1};
    vt[12] = '{32'h0000_0030, 16'hFFFF, 1'b0, '0, W3B, 1'b0};
    vt[13] = '{32'hFFFF_FFF0, 16'hFFFF, 1'b0, '0, '0, 1'b1};
`else
    vt[10] = '{32'h0000_1000, 16'hFFFF, 1'b0, '0, W0, 1'b0};
    vt[11] = '{32'h0000_1030, 16'hFFFF, 1'b1, ALL5, '0, 1'b0};
    vt[12] = '{32'h0000_0030, 16'hFFFF, 1'b0, '0, ALL5, 1'b0};
    vt[13] = '{32'hFFFF_FFF0, 16'hFFFF, 1'b0, '0, W255, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ack", 128'(ack_o), 128'(0));
    chk("reset_err", 128'(err_o), 128'(0));
    chk("reset_busy", 128'(busy_o), 128'(0));
    chk("reset_dat", dat_o[1], '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload every instance through the backdoor
    ld(0, W0); ld(2, W2); ld(3, W3); ld(5, '0); ld(7, W7); ld(9, W9); ld(255, W255);
    @(negedge clk);

    // Table-driven transfers on the one-wait-state instance
    for (int i = 0; i < 14; i++) begin
      xfer(1, vt[i].adr, vt[i].sel, vt[i].we, vt[i].wdat, vt[i].edat, vt[i].eerr, 2);
    end

    // A read whose RESP entry edge coincides with a preload of the same word returns the old data
    cur = 1; adr = 32'h20; sel = 16'hFFFF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    ld_we = 1'b1; ld_idx = 8'd2; ld_dat = Q2;
    @(negedge clk);
    ld_we = 1'b0;
    chk("ld_same_cycle_ack", 128'(ack_o[1]), 128'(1));
    chk("ld_same_cycle_old_data", dat_o[1], W2);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    xfer(1, 32'h20, 16'hFFFF, 1'b0, '0, Q2, 1'b0, 2);

    // Abort during WAIT on the three-wait-state instance
    cur = 2; adr = 32'h30; sel = 16'hFFFF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("abort_busy_in_wait", 128'(busy_o[2]), 128'(1));
    cyc = 1'b0; stb = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_o[2] || err_o[2]) seen = 1;
    end
    chk("abort_no_response", 128'(seen), 128'(0));
    chk("abort_back_to_idle", 128'(busy_o[2]), 128'(0));
    xfer(2, 32'h30, 16'hFFFF, 1'b0, '0, W3, 1'b0, 4);

    // Back-to-back reads with stb held on the zero-wait-state instance
    badr[0] = 32'h000; badr[1] = 32'h030; badr[2] = 32'h070; badr[3] = 32'hFF0;
    sb.push_back('{W0, 1'b0});
    sb.push_back('{W3, 1'b0});
    sb.push_back('{W7, 1'b0});
    sb.push_back('{W255, 1'b0});
    cur = 0; adr = badr[0]; sel = 16'hFFFF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    nack = 0; last = 0;
    for (int t = 1; t <= 12 && nack < 4; t++) begin
      @(negedge clk);
      if (ack_o[0]) begin
        e = sb.pop_front();
        chk($sformatf("b2b_data%0d", nack), dat_o[0], e.dat);
        if (nack == 0) chk("b2b_first_latency", 128'(t), 128'(1));
        else chk($sformatf("b2b_spacing%0d", nack), 128'(t - last), 128'(2));
        last = t;
        nack++;
        if (nack < 4) adr = badr[nack];
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_ack_count", 128'(nack), 128'(4));
    sb.delete();
    @(negedge clk);

    // Reset dropped mid-WAIT on a write: outputs clear at once and nothing is written
    xfer(2, 32'h90, 16'hFFFF, 1'b0, '0, W9, 1'b0, 4);
    cur = 2; adr = 32'h90; sel = 16'hFFFF; we = 1'b1; wdat = {16{8'h77}}; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midwait_busy_before_reset", 128'(busy_o[2]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_reset_ack", 128'(ack_o[2]), 128'(0));
    chk("midwait_reset_err", 128'(err_o[2]), 128'(0));
    chk("midwait_reset_busy", 128'(busy_o[2]), 128'(0));
    chk("midwait_reset_dat", dat_o[2], '0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(2, 32'h90, 16'hFFFF, 1'b0, '0, W9, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
